// File: rtl/exec_unit_param_if.sv
// Issue/CDB bus between a dispatch stage and exec_unit_param.
// The master side issues work and consumes broadcasts; the slave side is the exec unit.
interface exec_unit_param_if #(
  parameter int DW    = 8,
  parameter int ROB_W = 3,
  parameter int RS_W  = 3,
  parameter int RD_W  = 4
);
  logic              flush;
  logic              issue_valid;
  logic [3:0]        issue_func;
  logic [DW-1:0]     issue_a;
  logic [DW-1:0]     issue_b;
  logic [ROB_W-1:0]  issue_rob;
  logic [RD_W-1:0]   issue_rd;
  logic [RS_W-1:0]   issue_rs;
  logic              issue_ready_alu;
  logic              issue_ready_mul;
  logic              issue_ready_div;
  logic              illegal_func;
  logic              cdb_valid;
  logic [2*DW-1:0]   cdb_data;
  logic [ROB_W-1:0]  cdb_rob;
  logic [RD_W-1:0]   cdb_rd;
  logic [RS_W-1:0]   cdb_rs;
  logic [1:0]        cdb_unit;
  logic              cdb_dz;

  modport master (
    output flush, issue_valid, issue_func, issue_a, issue_b,
           issue_rob, issue_rd, issue_rs,
    input  issue_ready_alu, issue_ready_mul, issue_ready_div, illegal_func,
           cdb_valid, cdb_data, cdb_rob, cdb_rd, cdb_rs, cdb_unit, cdb_dz
  );

  modport slave (
    input  flush, issue_valid, issue_func, issue_a, issue_b,
           issue_rob, issue_rd, issue_rs,
    output issue_ready_alu, issue_ready_mul, issue_ready_div, illegal_func,
           cdb_valid, cdb_data, cdb_rob, cdb_rd, cdb_rs, cdb_unit, cdb_dz
  );
endinterface

// File: rtl/exec_unit_param.sv
// Execution cluster with a single issue port feeding three units: a one-cycle
// ADD/SUB ALU, a MUL_LAT-deep pipelined multiplier and a DW-cycle restoring
// divider. Each unit owns one holding register; a fixed-priority arbiter
// (DIV > MUL > ALU) picks which holding register drives the common data bus.
module exec_unit_param #(
  parameter int DW      = 8,
  parameter int ROB_W   = 3,
  parameter int RS_W    = 3,
  parameter int RD_W    = 4,
  parameter int MUL_LAT = 3
) (
  input logic clk,
  input logic rst,
  exec_unit_param_if.slave bus
);

  localparam logic [3:0] FUNC_ADD = 4'b0000;
  localparam logic [3:0] FUNC_SUB = 4'b0001;
  localparam logic [3:0] FUNC_MUL = 4'b0010;
  localparam logic [3:0] FUNC_DIV = 4'b0011;

  localparam logic [1:0] UNIT_ALU = 2'd0;
  localparam logic [1:0] UNIT_MUL = 2'd1;
  localparam logic [1:0] UNIT_DIV = 2'd2;

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

  // Opcode decode
  logic is_alu, is_mul, is_div, is_illegal;

  // Handshake and arbitration
  logic ready_alu, ready_mul, ready_div;
  logic accept_alu, accept_mul, accept_div;
  logic grant_alu, grant_mul, grant_div;
  logic mul_stall;

  // ALU datapath and holding register
  logic [DW:0]       alu_sum;
  logic [DW:0]       alu_diff;
  logic [2*DW-1:0]   alu_result;
  logic              alu_hold_valid;
  logic [2*DW-1:0]   alu_hold_data;
  logic [ROB_W-1:0]  alu_hold_rob;
  logic [RD_W-1:0]   alu_hold_rd;
  logic [RS_W-1:0]   alu_hold_rs;

  // Multiplier pipeline and holding register
  logic [2*DW-1:0]   mul_product;
  logic [MUL_LAT-1:0] mul_s_valid;
  logic [2*DW-1:0]   mul_s_prod [MUL_LAT];
  logic [ROB_W-1:0]  mul_s_rob  [MUL_LAT];
  logic [RD_W-1:0]   mul_s_rd   [MUL_LAT];
  logic [RS_W-1:0]   mul_s_rs   [MUL_LAT];
  logic              mul_hold_valid;
  logic [2*DW-1:0]   mul_hold_data;
  logic [ROB_W-1:0]  mul_hold_rob;
  logic [RD_W-1:0]   mul_hold_rd;
  logic [RS_W-1:0]   mul_hold_rs;

  // Divider state; in DONE the rem/quo working registers are the holding register
  div_state_t        div_state;
  logic [CW-1:0]     div_cnt;
  logic [DW-1:0]     div_rem;
  logic [DW-1:0]     div_quo;
  logic [DW-1:0]     div_divisor;
  logic              div_dz;
  logic [ROB_W-1:0]  div_rob;
  logic [RD_W-1:0]   div_rd;
  logic [RS_W-1:0]   div_rs;
  logic              div_busy;
  logic              div_hold_valid;
  logic [DW:0]       div_shift;
  logic              div_ge;
  logic [DW-1:0]     div_diff;
  logic [DW-1:0]     div_rem_next;
  logic [DW-1:0]     div_quo_next;

  // Broadcast mux outputs
  logic              cdb_valid_c;
  logic [2*DW-1:0]   cdb_data_c;
  logic [ROB_W-1:0]  cdb_rob_c;
  logic [RD_W-1:0]   cdb_rd_c;
  logic [RS_W-1:0]   cdb_rs_c;
  logic [1:0]        cdb_unit_c;
  logic              cdb_dz_c;
  logic              illegal_q;

  // Classify the presented opcode; anything outside 0000-0011 is illegal
  always_comb begin
    is_alu     = (bus.issue_func == FUNC_ADD) || (bus.issue_func == FUNC_SUB);
    is_mul     = (bus.issue_func == FUNC_MUL);
    is_div     = (bus.issue_func == FUNC_DIV);
    is_illegal = !(is_alu || is_mul || is_div);
  end

  // Fixed priority DIV > MUL > ALU; the multiplier stalls only when its output
  // stage has a result to hand over and its holding register cannot drain
  always_comb begin
    div_busy       = (div_state == DIV_BUSY);
    div_hold_valid = (div_state == DIV_DONE);
    grant_div      = div_hold_valid;
    grant_mul      = mul_hold_valid && !div_hold_valid;
    grant_alu      = alu_hold_valid && !div_hold_valid && !mul_hold_valid;
    mul_stall      = mul_s_valid[MUL_LAT-1] && mul_hold_valid && !grant_mul;
  end

  // Per-unit ready; reset and flush close every unit so nothing is accepted
  always_comb begin
    ready_alu  = !rst && !bus.flush && (!alu_hold_valid || grant_alu);
    ready_mul  = !rst && !bus.flush && !mul_stall;
    ready_div  = !rst && !bus.flush && !div_busy && !div_hold_valid;
    accept_alu = bus.issue_valid && is_alu && ready_alu;
    accept_mul = bus.issue_valid && is_mul && ready_mul;
    accept_div = bus.issue_valid && is_div && ready_div;
  end

  assign bus.issue_ready_alu = ready_alu;
  assign bus.issue_ready_mul = ready_mul;
  assign bus.issue_ready_div = ready_div;

  // ALU arithmetic: carry/borrow lands in bit DW, upper half stays zero
  always_comb begin
    alu_sum    = {1'b0, bus.issue_a} + {1'b0, bus.issue_b};
    alu_diff   = {1'b0, bus.issue_a} - {1'b0, bus.issue_b};
    alu_result = (bus.issue_func == FUNC_SUB) ? (2*DW)'(alu_diff) : (2*DW)'(alu_sum);
    mul_product = (2*DW)'(bus.issue_a) * (2*DW)'(bus.issue_b);
  end

  // ALU holding register: reload on accept, otherwise drain when granted
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      alu_hold_valid <= 1'b0;
    end else if (accept_alu) begin
      alu_hold_valid <= 1'b1;
      alu_hold_data  <= alu_result;
      alu_hold_rob   <= bus.issue_rob;
      alu_hold_rd    <= bus.issue_rd;
      alu_hold_rs    <= bus.issue_rs;
    end else if (grant_alu) begin
      alu_hold_valid <= 1'b0;
    end
  end

  // Multiplier pipeline: the whole pipe and its holding register freeze on stall
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      mul_s_valid    <= '0;
      mul_hold_valid <= 1'b0;
    end else if (!mul_stall) begin
      mul_s_valid[0] <= accept_mul;
      if (accept_mul) begin
        mul_s_prod[0] <= mul_product;
        mul_s_rob[0]  <= bus.issue_rob;
        mul_s_rd[0]   <= bus.issue_rd;
        mul_s_rs[0]   <= bus.issue_rs;
      end
      for (int i = 1; i < MUL_LAT; i++) begin
        mul_s_valid[i] <= mul_s_valid[i-1];
        mul_s_prod[i]  <= mul_s_prod[i-1];
        mul_s_rob[i]   <= mul_s_rob[i-1];
        mul_s_rd[i]    <= mul_s_rd[i-1];
        mul_s_rs[i]    <= mul_s_rs[i-1];
      end
      if (mul_s_valid[MUL_LAT-1]) begin
        mul_hold_valid <= 1'b1;
        mul_hold_data  <= mul_s_prod[MUL_LAT-1];
        mul_hold_rob   <= mul_s_rob[MUL_LAT-1];
        mul_hold_rd    <= mul_s_rd[MUL_LAT-1];
        mul_hold_rs    <= mul_s_rs[MUL_LAT-1];
      end else if (grant_mul) begin
        mul_hold_valid <= 1'b0;
      end
    end
  end

  // One restoring-division step; a zero divisor naturally yields all-ones
  // quotient and remainder equal to the dividend
  always_comb begin
    div_shift    = {div_rem, div_quo[DW-1]};
    div_ge       = (div_shift >= {1'b0, div_divisor});
    div_diff     = div_shift[DW-1:0] - div_divisor;
    div_rem_next = div_ge ? div_diff : div_shift[DW-1:0];
    div_quo_next = {div_quo[DW-2:0], div_ge};
  end

  // Divider FSM: IDLE -> BUSY for DW steps -> DONE until granted
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      div_state <= DIV_IDLE;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (accept_div) begin
            div_state   <= DIV_BUSY;
            div_rem     <= '0;
            div_quo     <= bus.issue_a;
            div_divisor <= bus.issue_b;
            div_dz      <= (bus.issue_b == '0);
            div_cnt     <= '0;
            div_rob     <= bus.issue_rob;
            div_rd      <= bus.issue_rd;
            div_rs      <= bus.issue_rs;
          end
        end
        DIV_BUSY: begin
          div_rem <= div_rem_next;
          div_quo <= div_quo_next;
          div_cnt <= div_cnt + CW'(1);
          if (div_cnt == DIV_LAST) begin
            div_state <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (grant_div) begin
            div_state <= DIV_IDLE;
          end
        end
        default: div_state <= DIV_IDLE;
      endcase
    end
  end

  // Illegal opcodes are swallowed and flagged for exactly one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= bus.issue_valid && is_illegal && !bus.flush;
    end
  end

  assign bus.illegal_func = illegal_q;

  // Drive the broadcast bus from the winning holding register, zero otherwise
  always_comb begin
    cdb_valid_c = 1'b0;
    cdb_data_c  = '0;
    cdb_rob_c   = '0;
    cdb_rd_c    = '0;
    cdb_rs_c    = '0;
    cdb_unit_c  = UNIT_ALU;
    cdb_dz_c    = 1'b0;
    if (grant_div) begin
      cdb_valid_c = 1'b1;
      cdb_data_c  = {div_rem, div_quo};
      cdb_rob_c   = div_rob;
      cdb_rd_c    = div_rd;
      cdb_rs_c    = div_rs;
      cdb_unit_c  = UNIT_DIV;
      cdb_dz_c    = div_dz;
    end else if (grant_mul) begin
      cdb_valid_c = 1'b1;
      cdb_data_c  = mul_hold_data;
      cdb_rob_c   = mul_hold_rob;
      cdb_rd_c    = mul_hold_rd;
      cdb_rs_c    = mul_hold_rs;
      cdb_unit_c  = UNIT_MUL;
    end else if (grant_alu) begin
      cdb_valid_c = 1'b1;
      cdb_data_c  = alu_hold_data;
      cdb_rob_c   = alu_hold_rob;
      cdb_rd_c    = alu_hold_rd;
      cdb_rs_c    = alu_hold_rs;
      cdb_unit_c  = UNIT_ALU;
    end
  end

  assign bus.cdb_valid = cdb_valid_c;
  assign bus.cdb_data  = cdb_data_c;
  assign bus.cdb_rob   = cdb_rob_c;
  assign bus.cdb_rd    = cdb_rd_c;
  assign bus.cdb_rs    = cdb_rs_c;
  assign bus.cdb_unit  = cdb_unit_c;
  assign bus.cdb_dz    = cdb_dz_c;

endmodule

// File: tb/tb_exec_unit_param.sv
// Bench for exec_unit_param: directed issues push hand-computed results into a
// scoreboard queue; an independent monitor pops and compares on every broadcast.
module tb_exec_unit_param;

  localparam int DW      = 8;
  localparam int ROB_W   = 3;
  localparam int RS_W    = 3;
  localparam int RD_W    = 4;
  localparam int MUL_LAT = 3;

  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0001;
  localparam logic [3:0] F_MUL = 4'b0010;
  localparam logic [3:0] F_DIV = 4'b0011;
  localparam logic [3:0] F_BAD = 4'b0110;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  rob;
    logic [3:0]  rd;
    logic [2:0]  rs;
    logic [1:0]  unit;
    logic        dz;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  exec_unit_param_if #(.DW(DW), .ROB_W(ROB_W), .RS_W(RS_W), .RD_W(RD_W)) bus ();

  exec_unit_param #(
    .DW(DW), .ROB_W(ROB_W), .RS_W(RS_W), .RD_W(RD_W), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one issue for a single cycle; queue the expected broadcast if any
  task automatic applyStimulus(input logic [3:0] func, input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] rob, input logic [3:0] rd, input logic [2:0] rs,
                               input bit expect_result, input logic [15:0] exp_data,
                               input logic exp_dz, input int lat);
    exp_t e;
    bus.issue_valid = 1'b1;
    bus.issue_func  = func;
    bus.issue_a     = a;
    bus.issue_b     = b;
    bus.issue_rob   = rob;
    bus.issue_rd    = rd;
    bus.issue_rs    = rs;
    if (expect_result) begin
      e.data = exp_data;
      e.rob  = rob;
      e.rd   = rd;
      e.rs   = rs;
      e.unit = (func == F_DIV) ? 2'd2 : ((func == F_MUL) ? 2'd1 : 2'd0);
      e.dz   = exp_dz;
      e.cyc  = cyc + lat;
      sb.push_back(e);
    end
    step();
    bus.issue_valid = 1'b0;
  endtask

  // Monitor: compare each broadcast against the scoreboard, idle bus must be zero
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.cdb_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_cdb: got cdb_valid=1 data=0x%0h expected no broadcast (cycle %0d)",
                   bus.cdb_data, cyc);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("cdb_data", 32'(bus.cdb_data), 32'(mon_e.data));
          checkOutput("cdb_tags", 32'({bus.cdb_unit, bus.cdb_dz, bus.cdb_rob, bus.cdb_rd, bus.cdb_rs}),
                      32'({mon_e.unit, mon_e.dz, mon_e.rob, mon_e.rd, mon_e.rs}));
          checkOutput("cdb_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end else begin
        checkOutput("cdb_idle_zero",
                    32'({bus.cdb_data, bus.cdb_rob, bus.cdb_rd, bus.cdb_rs, bus.cdb_unit, bus.cdb_dz}), 32'd0);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    n_fail++;
    $display("[TB] FAIL watchdog: got timeout expected normal completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Directed stimulus sequence
  initial begin
    rst             = 1'b1;
    bus.flush       = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_func  = '0;
    bus.issue_a     = '0;
    bus.issue_b     = '0;
    bus.issue_rob   = '0;
    bus.issue_rd    = '0;
    bus.issue_rs    = '0;
    step();
    mon_en = 1'b1;
    @(negedge clk);
    checkOutput("ready_in_reset", 32'({bus.issue_ready_alu, bus.issue_ready_mul, bus.issue_ready_div}), 32'd0);
    checkOutput("illegal_in_reset", 32'(bus.illegal_func), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'({bus.issue_ready_alu, bus.issue_ready_mul, bus.issue_ready_div}), 32'b111);
    step();

    $display("[TB] ALU back-to-back");
    applyStimulus(F_ADD, 8'd200, 8'd100, 3'd2, 4'd5, 3'd1, 1'b1, 16'h012C, 1'b0, 1);
    applyStimulus(F_SUB, 8'd5,   8'd7,   3'd3, 4'd6, 3'd2, 1'b1, 16'h01FE, 1'b0, 1);
    applyStimulus(F_SUB, 8'd100, 8'd30,  3'd4, 4'd7, 3'd3, 1'b1, 16'h0046, 1'b0, 1);
    applyStimulus(F_ADD, 8'd255, 8'd255, 3'd5, 4'd8, 3'd4, 1'b1, 16'h01FE, 1'b0, 1);
    repeat (3) step();

    $display("[TB] MUL back-to-back");
    applyStimulus(F_MUL, 8'd15,  8'd17,  3'd1, 4'd2, 3'd3, 1'b1, 16'h00FF, 1'b0, 4);
    applyStimulus(F_MUL, 8'd255, 8'd255, 3'd2, 4'd3, 3'd4, 1'b1, 16'hFE01, 1'b0, 4);
    applyStimulus(F_MUL, 8'd16,  8'd16,  3'd3, 4'd4, 3'd5, 1'b1, 16'h0100, 1'b0, 4);
    applyStimulus(F_MUL, 8'd0,   8'd200, 3'd4, 4'd5, 3'd6, 1'b1, 16'h0000, 1'b0, 4);
    repeat (6) step();

    $display("[TB] DIV normal and divide-by-zero");
    applyStimulus(F_DIV, 8'd100, 8'd7, 3'd6, 4'd9, 3'd2, 1'b1, 16'h020E, 1'b0, 9);
    @(negedge clk);
    checkOutput("ready_div_busy", 32'(bus.issue_ready_div), 32'd0);
    step();
    repeat (9) step();
    applyStimulus(F_DIV, 8'd9, 8'd0, 3'd7, 4'd10, 3'd1, 1'b1, 16'h09FF, 1'b1, 9);
    repeat (10) step();

    $display("[TB] DIV/MUL completion conflict");
    applyStimulus(F_DIV, 8'd255, 8'd16, 3'd1, 4'd11, 3'd6, 1'b1, 16'h0F0F, 1'b0, 9);
    repeat (4) step();
    applyStimulus(F_MUL, 8'd7, 8'd9, 3'd2, 4'd12, 3'd7, 1'b1, 16'h003F, 1'b0, 5);
    applyStimulus(F_MUL, 8'd3, 8'd5, 3'd3, 4'd13, 3'd0, 1'b1, 16'h000F, 1'b0, 5);
    for (int k = 7; k <= 11; k++) begin
      @(negedge clk);
      checkOutput("ready_mul_stall", 32'(bus.issue_ready_mul), (k == 9) ? 32'd0 : 32'd1);
      step();
    end
    repeat (2) step();

    $display("[TB] illegal opcode");
    applyStimulus(F_BAD, 8'd1, 8'd2, 3'd0, 4'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 0);
    @(negedge clk);
    checkOutput("illegal_pulse", 32'(bus.illegal_func), 32'd1);
    step();
    @(negedge clk);
    checkOutput("illegal_clear", 32'(bus.illegal_func), 32'd0);
    step();
    repeat (2) step();

    $display("[TB] flush with DIV and MUL in flight");
    applyStimulus(F_DIV, 8'd50, 8'd3, 3'd1, 4'd1, 3'd1, 1'b0, 16'h0000, 1'b0, 0);
    applyStimulus(F_MUL, 8'd2,  8'd3, 3'd2, 4'd2, 3'd2, 1'b0, 16'h0000, 1'b0, 0);
    step();
    bus.flush       = 1'b1;
    bus.issue_valid = 1'b1;
    bus.issue_func  = F_ADD;
    bus.issue_a     = 8'd1;
    bus.issue_b     = 8'd1;
    @(negedge clk);
    checkOutput("ready_in_flush", 32'({bus.issue_ready_alu, bus.issue_ready_mul, bus.issue_ready_div}), 32'd0);
    step();
    bus.flush       = 1'b0;
    bus.issue_valid = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_flush", 32'({bus.issue_ready_alu, bus.issue_ready_mul, bus.issue_ready_div}), 32'b111);
    checkOutput("cdb_after_flush", 32'(bus.cdb_valid), 32'd0);
    step();
    repeat (12) step();

    $display("[TB] reset over flush and issue mid-DIV");
    applyStimulus(F_DIV, 8'd20, 8'd4, 3'd3, 4'd3, 3'd3, 1'b0, 16'h0000, 1'b0, 0);
    applyStimulus(F_MUL, 8'd4,  8'd4, 3'd4, 4'd4, 3'd4, 1'b0, 16'h0000, 1'b0, 0);
    step();
    rst             = 1'b1;
    bus.flush       = 1'b1;
    bus.issue_valid = 1'b1;
    bus.issue_func  = F_ADD;
    @(negedge clk);
    checkOutput("ready_in_reset2", 32'({bus.issue_ready_alu, bus.issue_ready_mul, bus.issue_ready_div}), 32'd0);
    step();
    bus.flush       = 1'b0;
    bus.issue_valid = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset2", 32'({bus.issue_ready_alu, bus.issue_ready_mul, bus.issue_ready_div}), 32'b111);
    checkOutput("illegal_after_reset2", 32'(bus.illegal_func), 32'd0);
    step();
    repeat (12) step();

    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_unit_param.md
EXEC_UNIT_PARAM -- requirements
Module: exec_unit_param

Interface
REQ-001 SHALL have parameter DW, default 8, operand width in bits.
REQ-002 SHALL have parameter ROB_W, default 3, ROB index width.
REQ-003 SHALL have parameter RS_W, default 3, reservation-station index width.
REQ-004 SHALL have parameter RD_W, default 4, destination register index width.
REQ-005 SHALL have parameter MUL_LAT, default 3, multiplier pipeline depth (>=1).
REQ-006 SHALL have one clock and a synchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-007 SHALL have these ports:
- flush  in  1  discard all in-flight work
- issue_valid  in  1  issue request
- issue_func  in  4  opcode: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV
- issue_a, issue_b  in  DW each  operands
- issue_rob  in  ROB_W  ROB tag
- issue_rd  in  RD_W  destination register
- issue_rs  in  RS_W  RS slot
- issue_ready_alu, issue_ready_mul, issue_ready_div  out  1 each  per-unit ready
- illegal_func  out  1  one-cycle pulse on an unsupported opcode
- cdb_valid  out  1  result broadcast
- cdb_data  out  2*DW  result
- cdb_rob, cdb_rd, cdb_rs  out  tag fields echoed from issue
- cdb_unit  out  2  source unit: 0 ALU, 1 MUL, 2 DIV
- cdb_dz  out  1  divide-by-zero flag

Function
REQ-010 SHALL accept an issue in the cycle where issue_valid=1 and the ready output of the unit selected by issue_func is 1; the handshake is evaluated at the rising edge.
REQ-011 SHALL accept ADD/SUB on the ALU and register the result into alu_hold at the next edge: ADD = zero-extended a+b with carry in bit DW; SUB = a-b modulo 2^(DW+1) (borrow in bit DW); upper bits are zero.
REQ-012 SHALL compute MUL as the full unsigned 2*DW product through MUL_LAT pipeline stages; the product enters mul_hold MUL_LAT edges after acceptance when there is no stall.
REQ-013 SHALL compute DIV as an iterative unsigned restoring divider taking DW cycles, then load div_hold, with quotient in cdb_data[DW-1:0] and remainder in cdb_data[2*DW-1:DW].
REQ-014 SHALL handle DIV with b=0 as follows: quotient all ones, remainder = a, cdb_dz=1, same latency.
REQ-015 SHALL keep cdb_dz at 0 for all non-DIV results.
REQ-016 SHALL give each unit one holding register (valid plus data plus tags); cdb outputs are driven combinationally from the winning holding register only.
REQ-017 SHALL use fixed arbitration priority DIV > MUL > ALU; the winner is cleared at the edge; losers hold.
REQ-018 SHALL drive issue_ready_alu = !alu_hold_valid || alu_granted.
REQ-019 SHALL drive issue_ready_mul = !mul_stall, where mul_stall = last stage valid && mul_hold_valid && !mul_granted; when stalled, all MUL stages hold.
REQ-020 SHALL drive issue_ready_div = !div_busy && !div_hold_valid; DIV FSM states IDLE -> BUSY (DW cycles) -> DONE (hold valid) -> IDLE on grant.
REQ-021 SHALL accept an opcode other than 0000-0011 whenever issue_valid=1, assert illegal_func on the next cycle for one cycle, and produce no result.
REQ-022 SHALL drive the cdb outputs to 0 when cdb_valid=0.
REQ-023 SHALL, on flush=1, clear all holding registers, MUL stage valids and DIV state at the edge, force every ready output to 0 in that cycle, and drop any issue presented in that cycle; cdb_valid=0 in the following cycle.
REQ-024 SHALL sustain one ALU and one MUL acceptance per cycle when the CDB is uncontended; ALU and MUL issues are never accepted in the same cycle (single issue port).

Reset
REQ-030 SHALL, while rst=1 at an edge, clear all valids, DIV FSM to IDLE, illegal_func=0, cdb_valid=0 and all cdb fields 0; ready outputs are 0 during reset and 1 in the first cycle after rst deasserts.
REQ-031 SHALL give rst priority over flush and issue, including mid-DIV and with stalled MUL stages.

Verification
REQ-040 SHALL cover: ADD a=200 b=100 rob=2 rd=5, DW=8 -> next cycle cdb_valid=1, cdb_data=0x012C, cdb_unit=0, cdb_rob=2, cdb_rd=5.
REQ-041 SHALL cover: MUL a=15 b=17, MUL_LAT=3 -> cdb_data=0x00FF 3 cycles after acceptance; back-to-back MULs complete one per cycle.
REQ-042 SHALL cover: DIV a=100 b=7 -> after 8 busy cycles cdb_data={rem 2, quo 14}=0x020E, cdb_dz=0; DIV a=9 b=0 -> cdb_data=0x09FF, cdb_dz=1.
REQ-043 SHALL cover: DIV and MUL finishing in the same cycle -> DIV broadcast first, MUL the next cycle, MUL pipeline stalled with issue_ready_mul=0 for exactly the conflict cycle(s).
REQ-044 SHALL cover: flush asserted mid-DIV with MUL in flight -> no cdb_valid afterwards, all readies 1 the cycle after flush drops.
REQ-045 SHALL cover: issue_func=0110 -> illegal_func pulses once, no cdb_valid.
